mips_multicycle_control: RTL and testbench

Multi-cycle control FSM that drives the 5-bit ALU control code and all datapath enables/selects for the MIPS multi-cycle processor. It sequences fetch, decode, execute, memory and writeback, decodes opcode/funct into the ALU's operation codes, and consumes the ALU's Zero and OverFlow flags for branch resolution and overflow traps. It sits between the instruction register, the memory handshake and the ALU/register-file datapath.

---
 rtl/mips_multicycle_control_if.sv | 39 +++
 rtl/mips_multicycle_control.sv | 225 ++++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_control_if.sv
// Bundle of the control FSM's datapath, instruction and memory-handshake signals.
interface mips_multicycle_control_if;
  logic [31:0] instr;
  logic        mem_ready;
  logic        zero;
  logic        overflow;
  logic [4:0]  alu_control;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic        ext_sel;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic [1:0]  pc_src;
  logic        trap;
  logic [1:0]  trap_cause;
  logic        instr_done;
  logic [3:0]  state;

  // Control unit side: observes instruction/flags, drives enables and selects.
  modport master (
    input  instr, mem_ready, zero, overflow,
    output alu_control, alu_src_a, alu_src_b, ext_sel, mem_read, mem_write,
           ir_write, pc_write, reg_write, reg_dst, mem_to_reg, pc_src,
           trap, trap_cause, instr_done, state
  );

  // Datapath side: the mirror image of the control unit.
  modport slave (
    output instr, mem_ready, zero, overflow,
    input  alu_control, alu_src_a, alu_src_b, ext_sel, mem_read, mem_write,
           ir_write, pc_write, reg_write, reg_dst, mem_to_reg, pc_src,
           trap, trap_cause, instr_done, state
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// decodes opcode/funct into ALU codes and raises illegal/overflow traps.
module mips_multicycle_control (
  input  logic                       clk,
  input  logic                       reset,
  mips_multicycle_control_if.master  bus
);

  localparam int unsigned ALU_W = 5;
  localparam int unsigned SEL_W = 2;

  localparam logic [ALU_W-1:0] ALU_ADD   = 5'b00000;
  localparam logic [ALU_W-1:0] ALU_SUB   = 5'b00001;
  localparam logic [ALU_W-1:0] ALU_AND   = 5'b00010;
  localparam logic [ALU_W-1:0] ALU_OR    = 5'b00011;
  localparam logic [ALU_W-1:0] ALU_SRA   = 5'b00100;
  localparam logic [ALU_W-1:0] ALU_SRL   = 5'b00101;
  localparam logic [ALU_W-1:0] ALU_SLL   = 5'b00110;
  localparam logic [ALU_W-1:0] ALU_SLLV  = 5'b00111;
  localparam logic [ALU_W-1:0] ALU_SLT   = 5'b01000;
  localparam logic [ALU_W-1:0] ALU_ADDI  = 5'b01001;
  localparam logic [ALU_W-1:0] ALU_ADDIU = 5'b01010;
  localparam logic [ALU_W-1:0] ALU_ANDI  = 5'b01011;
  localparam logic [ALU_W-1:0] ALU_ORI   = 5'b01100;
  localparam logic [ALU_W-1:0] ALU_LUI   = 5'b01101;
  localparam logic [ALU_W-1:0] ALU_SLTIU = 5'b01110;
  localparam logic [ALU_W-1:0] ALU_SLTI  = 5'b01111;
  localparam logic [ALU_W-1:0] ALU_BEQ   = 5'b10000;
  localparam logic [ALU_W-1:0] ALU_BNE   = 5'b10001;
  localparam logic [ALU_W-1:0] ALU_LW    = 5'b10010;
  localparam logic [ALU_W-1:0] ALU_SW    = 5'b10011;

  localparam logic [SEL_W-1:0] CAUSE_ILLEGAL  = 2'b01;
  localparam logic [SEL_W-1:0] CAUSE_OVERFLOW = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_READ  = 4'd5,
    S_MEM_WB    = 4'd6,
    S_MEM_WRITE = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_TRAP      = 4'd11
  } state_t;

  state_t           state_q, state_nxt;
  logic [SEL_W-1:0] trap_cause_q, cause_nxt;

  logic [5:0] opcode, funct;
  assign opcode = bus.instr[31:26];
  assign funct  = bus.instr[5:0];

  // Register/shamt/immediate fields are consumed by the datapath, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^bus.instr[25:6];

  logic             r_legal, r_shift, r_ovf_chk;
  logic [ALU_W-1:0] r_code;
  logic             i_legal, i_zext, i_ovf_chk;
  logic [ALU_W-1:0] i_code;

  // R-type funct and I-type opcode decode tables.
  always_comb begin
    r_legal   = 1'b1;
    r_shift   = 1'b0;
    r_ovf_chk = 1'b0;
    r_code    = ALU_ADD;
    case (funct)
      6'h20: begin r_code = ALU_ADD;  r_ovf_chk = 1'b1; end
      6'h22: begin r_code = ALU_SUB;  r_ovf_chk = 1'b1; end
      6'h24: r_code = ALU_AND;
      6'h25: r_code = ALU_OR;
      6'h03: begin r_code = ALU_SRA;  r_shift = 1'b1; end
      6'h02: begin r_code = ALU_SRL;  r_shift = 1'b1; end
      6'h00: begin r_code = ALU_SLL;  r_shift = 1'b1; end
      6'h04: r_code = ALU_SLLV;
      6'h2A: r_code = ALU_SLT;
      default: r_legal = 1'b0;
    endcase

    i_legal   = 1'b1;
    i_zext    = 1'b0;
    i_ovf_chk = 1'b0;
    i_code    = ALU_ADD;
    case (opcode)
      6'h08: begin i_code = ALU_ADDI; i_ovf_chk = 1'b1; end
      6'h09: i_code = ALU_ADDIU;
      6'h0C: begin i_code = ALU_ANDI; i_zext = 1'b1; end
      6'h0D: begin i_code = ALU_ORI;  i_zext = 1'b1; end
      6'h0F: begin i_code = ALU_LUI;  i_zext = 1'b1; end
      6'h0A: i_code = ALU_SLTI;
      6'h0B: i_code = ALU_SLTIU;
      default: i_legal = 1'b0;
    endcase
  end

  // State register; trap cause is captured only on the edge entering TRAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      trap_cause_q <= 2'b00;
    end else begin
      state_q <= state_nxt;
      if (state_nxt == S_TRAP) trap_cause_q <= cause_nxt;
    end
  end

  // Next-state and datapath controls; everything held inactive during reset.
  always_comb begin
    state_nxt       = state_q;
    cause_nxt       = CAUSE_ILLEGAL;
    bus.alu_control = ALU_ADD;
    bus.alu_src_a   = 2'b00;
    bus.alu_src_b   = 2'b00;
    bus.ext_sel     = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.ir_write    = 1'b0;
    bus.pc_write    = 1'b0;
    bus.reg_write   = 1'b0;
    bus.reg_dst     = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.pc_src      = 2'b00;
    bus.trap        = 1'b0;
    bus.instr_done  = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            state_nxt    = S_DECODE;
          end
        end
        S_DECODE: begin
          bus.alu_src_b = 2'b11;
          cause_nxt     = CAUSE_ILLEGAL;
          if (opcode == 6'h00)                     state_nxt = r_legal ? S_EXEC_R : S_TRAP;
          else if (i_legal)                        state_nxt = S_EXEC_I;
          else if (opcode == 6'h23 || opcode == 6'h2B) state_nxt = S_MEM_ADDR;
          else if (opcode == 6'h04 || opcode == 6'h05) state_nxt = S_BRANCH;
          else if (opcode == 6'h02)                state_nxt = S_JUMP;
          else                                     state_nxt = S_TRAP;
        end
        S_EXEC_R: begin
          bus.alu_control = r_code;
          bus.alu_src_a   = r_shift ? 2'b10 : 2'b01;
          bus.alu_src_b   = 2'b00;
          cause_nxt       = CAUSE_OVERFLOW;
          state_nxt       = (r_ovf_chk && bus.overflow) ? S_TRAP : S_ALU_WB;
        end
        S_EXEC_I: begin
          bus.alu_control = i_code;
          bus.alu_src_a   = 2'b01;
          bus.alu_src_b   = 2'b10;
          bus.ext_sel     = i_zext;
          cause_nxt       = CAUSE_OVERFLOW;
          state_nxt       = (i_ovf_chk && bus.overflow) ? S_TRAP : S_ALU_WB;
        end
        S_ALU_WB: begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = (opcode == 6'h00);
          bus.instr_done = 1'b1;
          state_nxt      = S_FETCH;
        end
        S_MEM_ADDR: begin
          bus.alu_control = (opcode == 6'h23) ? ALU_LW : ALU_SW;
          bus.alu_src_a   = 2'b01;
          bus.alu_src_b   = 2'b10;
          state_nxt       = (opcode == 6'h23) ? S_MEM_READ : S_MEM_WRITE;
        end
        S_MEM_READ: begin
          bus.mem_read = 1'b1;
          if (bus.mem_ready) state_nxt = S_MEM_WB;
        end
        S_MEM_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
          bus.instr_done = 1'b1;
          state_nxt      = S_FETCH;
        end
        S_MEM_WRITE: begin
          bus.mem_write = 1'b1;
          if (bus.mem_ready) begin
            bus.instr_done = 1'b1;
            state_nxt      = S_FETCH;
          end
        end
        S_BRANCH: begin
          bus.alu_control = (opcode == 6'h04) ? ALU_BEQ : ALU_BNE;
          bus.alu_src_a   = 2'b01;
          bus.alu_src_b   = 2'b00;
          bus.pc_src      = 2'b01;
          bus.pc_write    = (opcode == 6'h04) ? bus.zero : ~bus.zero;
          bus.instr_done  = 1'b1;
          state_nxt       = S_FETCH;
        end
        S_JUMP: begin
          bus.pc_write   = 1'b1;
          bus.pc_src     = 2'b10;
          bus.instr_done = 1'b1;
          state_nxt      = S_FETCH;
        end
        S_TRAP: begin
          bus.trap     = 1'b1;
          bus.pc_write = 1'b1;
          bus.pc_src   = 2'b11;
          state_nxt    = S_FETCH;
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  assign bus.state      = 4'(state_q);
  assign bus.trap_cause = trap_cause_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized self-checking bench for mips_multicycle_control against an
// instruction-level model: each instruction class expands to its expected
// sequence of controller steps.
module tb_mips_multicycle_control;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [1:0] exp_cause;

  mips_multicycle_control_if bus();

  mips_multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int CL_R = 0, CL_I = 1, CL_LW = 2, CL_SW = 3, CL_BR = 4, CL_J = 5, CL_ILL = 6;

  logic [5:0] r_fns [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h03, 6'h02, 6'h00, 6'h04, 6'h2A};
  logic [5:0] i_ops [7] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h0A, 6'h0B};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Instruction class from the opcode/funct legality rules.
  function automatic int classify(input logic [31:0] iw);
    logic [5:0] op, fn;
    op = iw[31:26];
    fn = iw[5:0];
    if (op == 6'h00) return (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h03, 6'h02, 6'h00, 6'h04, 6'h2A}) ? CL_R : CL_ILL;
    if (op inside {6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h0A, 6'h0B}) return CL_I;
    if (op == 6'h23) return CL_LW;
    if (op == 6'h2B) return CL_SW;
    if (op == 6'h04 || op == 6'h05) return CL_BR;
    if (op == 6'h02) return CL_J;
    return CL_ILL;
  endfunction

  // ALU code for the execute/branch step.
  function automatic int ref_code(input logic [31:0] iw);
    logic [5:0] op, fn;
    op = iw[31:26];
    fn = iw[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h20: return 0;  6'h22: return 1;  6'h24: return 2;
        6'h25: return 3;  6'h03: return 4;  6'h02: return 5;
        6'h00: return 6;  6'h04: return 7;  6'h2A: return 8;
        default: return 0;
      endcase
    end
    case (op)
      6'h08: return 9;   6'h09: return 10;  6'h0C: return 11;
      6'h0D: return 12;  6'h0F: return 13;  6'h0B: return 14;
      6'h0A: return 15;  6'h04: return 16;  6'h05: return 17;
      6'h23: return 18;  6'h2B: return 19;
      default: return 0;
    endcase
  endfunction

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_in(input logic mr);
    bus.mem_ready = mr;
    bus.zero      = 1'($urandom);
    bus.overflow  = 1'($urandom);
  endtask

  task automatic expect_o(input string tg, input int st, input int alu, input int sa, input int sb,
                          input int ext, input int mr, input int mw, input int irw, input int pcw,
                          input int rw, input int rd, input int m2r, input int pcs, input int trp,
                          input int done);
    chk({tg, ".state"},      32'(bus.state),       32'(st));
    chk({tg, ".alu"},        32'(bus.alu_control), 32'(alu));
    chk({tg, ".src_a"},      32'(bus.alu_src_a),   32'(sa));
    chk({tg, ".src_b"},      32'(bus.alu_src_b),   32'(sb));
    chk({tg, ".ext_sel"},    32'(bus.ext_sel),     32'(ext));
    chk({tg, ".mem_read"},   32'(bus.mem_read),    32'(mr));
    chk({tg, ".mem_write"},  32'(bus.mem_write),   32'(mw));
    chk({tg, ".ir_write"},   32'(bus.ir_write),    32'(irw));
    chk({tg, ".pc_write"},   32'(bus.pc_write),    32'(pcw));
    chk({tg, ".reg_write"},  32'(bus.reg_write),   32'(rw));
    chk({tg, ".reg_dst"},    32'(bus.reg_dst),     32'(rd));
    chk({tg, ".mem_to_reg"}, 32'(bus.mem_to_reg),  32'(m2r));
    chk({tg, ".pc_src"},     32'(bus.pc_src),      32'(pcs));
    chk({tg, ".trap"},       32'(bus.trap),        32'(trp));
    chk({tg, ".done"},       32'(bus.instr_done),  32'(done));
    chk({tg, ".cause"},      32'(bus.trap_cause),  32'(exp_cause));
  endtask

  task automatic trap_step(input logic [1:0] cause);
    rand_in(1'($urandom));
    exp_cause = cause;
    @(negedge clk);
    expect_o("trap", 11, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 1, 0);
    adv();
  endtask

  task automatic fetch_decode(input logic [31:0] iw, input int fst);
    bus.instr = $urandom;
    for (int k = 0; k < fst; k++) begin
      rand_in(1'b0);
      @(negedge clk);
      expect_o("fetch_wait", 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      adv();
    end
    rand_in(1'b1);
    @(negedge clk);
    expect_o("fetch", 0, 0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    adv();
    bus.instr = iw;
    rand_in(1'($urandom));
    @(negedge clk);
    expect_o("decode", 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    adv();
  endtask

  // Drive one instruction through the controller and check every step.
  task automatic run_instr(input logic [31:0] iw, input int fst, input int mst,
                           input logic zf, input logic of);
    logic [5:0] op, fn;
    int cl, code;
    logic ovf_trap, taken;
    op   = iw[31:26];
    fn   = iw[5:0];
    cl   = classify(iw);
    code = ref_code(iw);
    fetch_decode(iw, fst);
    case (cl)
      CL_R: begin
        rand_in(1'($urandom));
        bus.overflow = of;
        ovf_trap = of && (fn == 6'h20 || fn == 6'h22);
        @(negedge clk);
        expect_o("exec_r", 2, code, (fn inside {6'h00, 6'h02, 6'h03}) ? 2 : 1, 0,
                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv();
        if (ovf_trap) trap_step(2'b10);
        else begin
          rand_in(1'($urandom));
          @(negedge clk);
          expect_o("alu_wb_r", 8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
          adv();
        end
      end
      CL_I: begin
        rand_in(1'($urandom));
        bus.overflow = of;
        ovf_trap = of && (op == 6'h08);
        @(negedge clk);
        expect_o("exec_i", 3, code, 1, 2, (op inside {6'h0C, 6'h0D, 6'h0F}) ? 1 : 0,
                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv();
        if (ovf_trap) trap_step(2'b10);
        else begin
          rand_in(1'($urandom));
          @(negedge clk);
          expect_o("alu_wb_i", 8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
          adv();
        end
      end
      CL_LW, CL_SW: begin
        rand_in(1'($urandom));
        @(negedge clk);
        expect_o("mem_addr", 4, code, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv();
        for (int k = 0; k <= mst; k++) begin
          rand_in(k == mst);
          @(negedge clk);
          if (cl == CL_LW)
            expect_o("mem_read", 5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
          else
            expect_o("mem_write", 7, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, (k == mst) ? 1 : 0);
          adv();
        end
        if (cl == CL_LW) begin
          rand_in(1'($urandom));
          @(negedge clk);
          expect_o("mem_wb", 6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1);
          adv();
        end
      end
      CL_BR: begin
        rand_in(1'($urandom));
        bus.zero = zf;
        taken = (op == 6'h04) ? zf : !zf;
        @(negedge clk);
        expect_o("branch", 9, code, 1, 0, 0, 0, 0, 0, taken ? 1 : 0, 0, 0, 0, 1, 0, 1);
        adv();
      end
      CL_J: begin
        rand_in(1'($urandom));
        @(negedge clk);
        expect_o("jump", 10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 1);
        adv();
      end
      default: trap_step(2'b01);
    endcase
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] iw;
    int cat;
    iw  = $urandom;
    cat = $urandom_range(0, 8);
    case (cat)
      0, 1: begin iw[31:26] = 6'h00; iw[5:0] = r_fns[$urandom_range(0, 8)]; end
      2, 3: iw[31:26] = i_ops[$urandom_range(0, 6)];
      4:    iw[31:26] = $urandom_range(0, 1) ? 6'h23 : 6'h2B;
      5:    iw[31:26] = $urandom_range(0, 1) ? 6'h04 : 6'h05;
      6:    iw[31:26] = 6'h02;
      7: begin
        iw[31:26] = 6'h00;
        while (classify(iw) != CL_ILL) iw[5:0] = 6'($urandom);
      end
      default: begin
        iw[31:26] = 6'h3F;
        while (classify(iw) != CL_ILL) iw[31:26] = 6'($urandom);
      end
    endcase
    return iw;
  endfunction

  // Reset asserted for three cycles while a load waits in MEM_READ.
  task automatic reset_mid_lw();
    fetch_decode(32'h8C220004, 0);
    rand_in(1'($urandom));
    @(negedge clk);
    expect_o("rst_maddr", 4, 18, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    adv();
    rand_in(1'b0);
    @(negedge clk);
    expect_o("rst_mread", 5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    expect_o("rst_gate", 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    adv();
    exp_cause = 2'b00;
    for (int k = 0; k < 3; k++) begin
      rand_in(1'($urandom));
      @(negedge clk);
      expect_o("rst_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (k < 2) adv();
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    exp_cause = 2'b00;
    reset     = 1'b1;
    bus.instr = 32'h0;
    rand_in(1'b0);
    adv();
    adv();
    @(negedge clk);
    expect_o("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    adv();
    reset = 1'b0;

    run_instr(32'h00221820, 0, 0, 1'b0, 1'b0);  // add
    run_instr(32'h00011100, 1, 0, 1'b0, 1'b1);  // sll
    run_instr(32'h34220F0F, 0, 0, 1'b0, 1'b1);  // ori
    run_instr(32'h8C220004, 2, 3, 1'b0, 1'b0);  // lw, stalled load
    run_instr(32'hAC220004, 0, 2, 1'b0, 1'b0);  // sw
    run_instr(32'h10220003, 0, 0, 1'b1, 1'b0);  // beq taken
    run_instr(32'h10220003, 0, 0, 1'b0, 1'b0);  // beq not taken
    run_instr(32'h14220003, 0, 0, 1'b1, 1'b0);  // bne not taken
    run_instr(32'h14220003, 0, 0, 1'b0, 1'b0);  // bne taken
    run_instr(32'h08000010, 0, 0, 1'b0, 1'b0);  // j
    run_instr(32'h20220001, 0, 0, 1'b0, 1'b1);  // addi overflow trap
    run_instr(32'h24220001, 0, 0, 1'b0, 1'b1);  // addiu overflow ignored
    run_instr(32'h00221822, 0, 0, 1'b0, 1'b1);  // sub overflow trap
    run_instr(32'hFC000000, 0, 0, 1'b0, 1'b0);  // opcode 3F illegal
    run_instr(32'h0022182A, 0, 0, 1'b0, 1'b1);  // slt, overflow ignored

    reset_mid_lw();

    for (int n = 0; n < 300; n++)
      run_instr(gen_instr(), $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
